// File: rtl/instr_sequencer_if.sv
// Program-load, start/done and instruction-issue signals between the
// instruction sequencer and whatever loads and drives it.
interface instr_sequencer_if #(
    parameter int ADDR_W = 4
);
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [24:0]       load_data;
    logic              start;
    logic              done;
    logic [8:0]        ir;
    logic [15:0]       din;
    logic              run;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              halted;
    logic              fault;

    modport master (
        input  load_en, load_addr, load_data, start, done,
        output ir, din, run, pc, busy, halted, fault
    );

    modport slave (
        output load_en, load_addr, load_data, start, done,
        input  ir, din, run, pc, busy, halted, fault
    );
endinterface

// File: rtl/instr_sequencer.sv
// Feeds a stored program to the pratica2 processor one instruction at a
// time, waiting on done, with halt detection and a watchdog.
module instr_sequencer #(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic clock,
    input  logic resetn,
    instr_sequencer_if.master bus
);
    localparam int WD_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        HALT,
        FAULT
    } state_t;

    state_t            state;
    logic [24:0]       mem [DEPTH];
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic [WD_W-1:0]   wd;
    logic              run;
    logic              busy;
    logic              halted;
    logic              fault;
    logic              wr;
    logic [2:0]        op_first;
    logic [2:0]        op_cur;
    logic [2:0]        op_next;

    assign wr     = bus.load_en && !busy;
    assign pc_inc = pc + 1'b1;
    assign op_cur  = mem[pc][24:22];
    assign op_next = mem[pc_inc][24:22];

    // A write to entry 0 on the start edge must be seen by the first issue.
    assign op_first = (wr && bus.load_addr == '0) ?
                      bus.load_data[24:22] : mem[0][24:22];

    assign bus.ir     = mem[pc][24:16];
    assign bus.din    = mem[pc][15:0];
    assign bus.pc     = pc;
    assign bus.run    = run;
    assign bus.busy   = busy;
    assign bus.halted = halted;
    assign bus.fault  = fault;

    always_ff @(posedge clock) begin
        if (!resetn && wr)
            mem[bus.load_addr] <= bus.load_data;
    end

    always_ff @(posedge clock) begin
        if (resetn) begin
            state  <= IDLE;
            pc     <= '0;
            wd     <= '0;
            run    <= 1'b0;
            busy   <= 1'b0;
            halted <= 1'b0;
            fault  <= 1'b0;
        end else begin
            run <= 1'b0;
            unique case (state)
                IDLE, HALT, FAULT: begin
                    if (bus.start) begin
                        state  <= ISSUE;
                        pc     <= '0;
                        wd     <= '0;
                        busy   <= 1'b1;
                        halted <= 1'b0;
                        fault  <= 1'b0;
                        run    <= (op_first != 3'b111);
                    end
                end
                ISSUE: begin
                    if (op_cur == 3'b111) begin
                        state  <= HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.done) begin
                        wd <= '0;
                        if (pc == ADDR_W'(DEPTH - 1)) begin
                            state  <= HALT;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end else begin
                            state <= ISSUE;
                            pc    <= pc_inc;
                            run   <= (op_next != 3'b111);
                        end
                    end else if (wd == WD_W'(TIMEOUT - 1)) begin
                        state <= FAULT;
                        wd    <= '0;
                        busy  <= 1'b0;
                        fault <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: expected issues are queued by the
// stimulus and checked by a monitor on every run pulse.
module tb_instr_sequencer;
    typedef struct packed {
        logic [8:0]  ir;
        logic [15:0] din;
        logic [3:0]  pc;
    } exp_t;

    logic clock = 1'b0;
    logic resetn = 1'b1;
    always #5 clock = ~clock;

    instr_sequencer_if #(.ADDR_W(4)) bus ();

    instr_sequencer #(
        .DEPTH(16),
        .ADDR_W(4),
        .TIMEOUT(64)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .bus(bus)
    );

    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    run_count = 0;
    int    prev_run = -1;
    int    gap_req = 0;
    int    done_delay = 1;
    int    stop_pc = -1;
    bit    auto_done = 1'b0;
    exp_t  q[$];
    logic [24:0] prog [16];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: every run pulse must match the next queued expectation.
    always @(negedge clock) begin
        if (bus.run === 1'b1) begin
            exp_t e;
            run_count++;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_run: got pc=%0d ir=%h expected none",
                         bus.pc, bus.ir);
            end else begin
                e = q.pop_front();
                chk("run_ir", 32'(bus.ir), 32'(e.ir));
                chk("run_din", 32'(bus.din), 32'(e.din));
                chk("run_pc", 32'(bus.pc), 32'(e.pc));
            end
            if (gap_req != 0 && prev_run >= 0)
                chk("run_gap", cyc - prev_run, gap_req);
            prev_run = cyc;
        end
    end

    // Processor stand-in: registered done reply after each run.
    initial begin
        forever begin
            @(negedge clock);
            if (bus.run === 1'b1 && auto_done && int'(bus.pc) != stop_pc) begin
                repeat (done_delay + 1) @(posedge clock);
                #1 bus.done = 1'b1;
                @(posedge clock);
                #1 bus.done = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input int addr, input logic [24:0] data);
        bus.load_en   = 1'b1;
        bus.load_addr = 4'(addr);
        bus.load_data = data;
        tick();
        bus.load_en = 1'b0;
        prog[addr] = data;
    endtask

    task automatic push(input int idx);
        exp_t e;
        e.ir  = prog[idx][24:16];
        e.din = prog[idx][15:0];
        e.pc  = 4'(idx);
        q.push_back(e);
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b1;
        tick();
        resetn = 1'b0;
    endtask

    task automatic wait_cond(input int sel, input int maxc);
        bit hit = 1'b0;
        for (int i = 0; i < maxc && !hit; i++) begin
            @(negedge clock);
            case (sel)
                0:       hit = bus.halted;
                1:       hit = bus.fault;
                default: hit = bus.run && bus.pc == 4'd5;
            endcase
        end
        chk("wait_cond", 32'(hit), 32'd1);
    endtask

    task automatic chk_flags(input string tag, input logic [3:0] pc,
                             input logic run, input logic busy,
                             input logic halted, input logic fault);
        chk({tag, "_pc"}, 32'(bus.pc), 32'(pc));
        chk({tag, "_run"}, 32'(bus.run), 32'(run));
        chk({tag, "_busy"}, 32'(bus.busy), 32'(busy));
        chk({tag, "_halted"}, 32'(bus.halted), 32'(halted));
        chk({tag, "_fault"}, 32'(bus.fault), 32'(fault));
    endtask

    initial begin
        int base;
        int run_cyc;
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        bus.start     = 1'b0;
        bus.done      = 1'b0;
        repeat (3) tick();
        resetn = 1'b0;
        chk_flags("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Short program ending in HALT.
        load(0, {9'b001_000_000, 16'h0005});
        load(1, {9'b000_001_000, 16'h0000});
        load(2, {9'b111_000_000, 16'h0000});
        push(0);
        push(1);
        auto_done  = 1'b1;
        done_delay = 3;
        base = run_count;
        do_start();
        chk("start_busy", 32'(bus.busy), 32'd1);
        wait_cond(0, 100);
        chk_flags("prog_halt", 4'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("prog_runs", run_count - base, 2);

        // Full memory, no halt word: stops at the last entry.
        for (int i = 0; i < 16; i++)
            load(i, {9'(i * 8 + 1), 16'h1000 + 16'(i)});
        for (int i = 0; i < 16; i++) push(i);
        done_delay = 1;
        gap_req    = 3;
        prev_run   = -1;
        base       = run_count;
        do_start();
        wait_cond(0, 100);
        repeat (5) tick();
        chk_flags("full_halt", 4'd15, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("full_runs", run_count - base, 16);
        chk("full_queue", q.size(), 0);
        gap_req = 0;

        // Write while halted shows up on ir/din the next cycle.
        load(15, {9'h0AB, 16'hBEEF});
        chk("wr_vis_ir", 32'(bus.ir), 32'h0AB);
        chk("wr_vis_din", 32'(bus.din), 32'hBEEF);

        // Watchdog timeout.
        auto_done = 1'b0;
        push(0);
        do_start();
        run_cyc = cyc;
        wait_cond(1, 100);
        chk("fault_delay", cyc - run_cyc, 65);
        chk_flags("fault", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Restart from FAULT, then done exactly at watchdog 63.
        push(0);
        do_start();
        chk_flags("restart", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (63) tick();
        chk("pre_edge_fault", 32'(bus.fault), 32'd0);
        tick();
        push(1);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        chk_flags("edge_done", 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (2) tick();
        do_reset();
        chk_flags("rst_wait1", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // load_en and start while busy are ignored.
        for (int i = 0; i < 16; i++) push(i);
        auto_done  = 1'b1;
        done_delay = 3;
        do_start();
        tick();
        bus.load_en   = 1'b1;
        bus.load_addr = 4'd0;
        bus.load_data = 25'h1FF_FFFF;
        bus.start     = 1'b1;
        tick();
        bus.load_en = 1'b0;
        bus.start   = 1'b0;
        wait_cond(0, 300);
        chk("busy_halt_pc", 32'(bus.pc), 32'd15);
        chk("busy_queue", q.size(), 0);
        do_reset();
        chk("mem0_ir", 32'(bus.ir), 32'h001);
        chk("mem0_din", 32'(bus.din), 32'h1000);

        // Reset in the middle of WAIT at entry 5.
        for (int i = 0; i < 6; i++) push(i);
        done_delay = 1;
        stop_pc    = 5;
        do_start();
        wait_cond(2, 100);
        repeat (2) tick();
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        do_reset();
        chk_flags("rst_mid", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_queue", q.size(), 0);
        push(0);
        stop_pc = 0;
        do_start();
        chk_flags("rerun", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("rerun_run_low", 32'(bus.run), 32'd0);
        repeat (3) tick();
        chk("rerun_queue", q.size(), 0);
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Program-feeding initiator for the `pratica2` processor. It holds a small program of instruction words with optional immediate data and presents them one at a time on the processor's `ir`/`din`/`run` inputs. It then waits for the processor's `done` before advancing. It replaces manual switch-driven stepping. It also detects halt instructions, end of program and hung instructions (watchdog timeout).

## Interface
- `DEPTH`, 16: program memory entries; power of two, 2..256.
- `ADDR_W`, 4: width of `pc`/`load_addr`; equals log2(DEPTH).
- `TIMEOUT`, 64: maximum cycles spent waiting for `done` before faulting; must be ≥ 2.
- `clock` in 1: single clock; everything is sampled on its rising edge.
- `resetn` in 1: synchronous, active-high reset. Asserted (1) means reset.
- `load_en` in 1: program write strobe. It is honoured only when `busy`=0.
- `load_addr` in ADDR_W: write address.
- `load_data` in 25: {ir[8:0], din[15:0]} written into the entry.
- `start` in 1: one-cycle pulse that begins execution at entry 0.
- `done` in 1: processor completion, from the `pratica2` control unit.
- `ir` out 9: instruction to the processor, format III XXX YYY.
- `din` out 16: immediate data for the current entry.
- `run` out 1: high for exactly one cycle per issued instruction.
- `pc` out ADDR_W: index of the current entry.
- `busy` out 1: high in the ISSUE and WAIT states.
- `halted` out 1: high in the HALT state.
- `fault` out 1: high in the FAULT state.

## Operation
- Memory: DEPTH×25 register array. It is not cleared by reset. Reads are asynchronous.
- `ir`/`din` always equal `mem[pc]`. They are driven from state regardless of the current state, and stay stable for the whole of ISSUE and WAIT.
- Halt opcode: `ir[8:6]`=3'b111 is reserved as HALT. It is never issued to the processor.
- State machine:
  - **IDLE**: `start` sets `pc`←0, clears the watchdog and moves to ISSUE.
  - **ISSUE**: if the opcode of `mem[pc]` is 111, move to HALT with `run`=0. Otherwise `run`=1 for this single cycle and move to WAIT. `done` is ignored in ISSUE.
  - **WAIT**: `run`=0 and the watchdog increments every cycle. The outcome depends on the first matching condition:
    - If `done`=1 and `pc`=DEPTH−1, move to HALT.
    - If `done`=1 otherwise, `pc`←`pc`+1, clear the watchdog and move to ISSUE.
    - If `done`=0 and the watchdog equals TIMEOUT−1, move to FAULT.
    - `done` takes priority over a timeout in the same cycle.
  - **HALT** / **FAULT**: `pc` is frozen. `start` sets `pc`←0, clears the watchdog and moves to ISSUE.
- `start` during ISSUE or WAIT is ignored.
- `load_en` while `busy`=1 is ignored and the memory is unchanged.
- Writes are legal in IDLE, HALT and FAULT.
- Watchdog: counter of width ceil(log2(TIMEOUT)). It is held at 0 outside WAIT.
- Reset forces, on the next edge, from any state including mid-WAIT:
  - state IDLE;
  - `pc`=0 and watchdog 0;
  - `run`=0, `busy`=0, `halted`=0, `fault`=0;
  - `ir`/`din` show `mem[0]`.
- Reset has priority over `start` and `load_en`.

## Timing
- Edge E samples `start` in IDLE: at E+1 `run`=1 with `ir`=`mem[0]`, and `busy`=1.
- At E+2 `run`=0.
- Edge D samples `done`=1 in WAIT: at D+1 `pc` has advanced and `run`=1 for the next instruction. The minimum issue-to-issue spacing is 2 cycles.
- Back-to-back `done` pulses count only once: a `done` during ISSUE is dropped.
- Timeout: the watchdog is 0 in the first WAIT cycle. WAIT with no `done` for TIMEOUT consecutive cycles gives `fault`=1 on the following cycle.
- `halted` and `fault` are mutually exclusive. Each stays high until `start` or reset.
- A write on edge W is visible on `ir`/`din` from W+1 if `pc` equals `load_addr`.

## Test plan
- Load entries 0..2 = {001_000_000, 0x0005}, {000_001_000, 0}, {111_000_000, 0}, then `start`; reply `done` 3 cycles after each `run`.
  - Required: two `run` pulses, with `ir`=0x040 then 0x008 and `din`=0x0005 on the first; then `halted`=1 and `pc`=2, with no third `run`.
- Fill all 16 entries with non-halt words and `done` one cycle after each `run`.
  - Required: 16 `run` pulses spaced 3 cycles apart; `halted`=1 at `pc`=15; no wrap to 0.
- TIMEOUT=64, never assert `done`.
  - Required: `fault`=1 exactly 65 cycles after `run`; then `start` restarts with `pc`=0 and `fault`=0.
- Assert `done` on the same cycle the watchdog reaches 63.
  - Required: no fault; `pc`→1.
- Pulse `load_en` to address 0 and `start` while `busy`=1.
  - Required: memory unchanged; execution unaffected.
- Assert `resetn`=1 mid-WAIT at `pc`=5.
  - Required: next cycle IDLE, `pc`=0, all flags 0, `run`=0; a following `start` re-executes from entry 0.
